byte_load_sequencer: RTL

BYTE_LOAD_SEQUENCER -- requirements
Module: byte_load_sequencer

---
 rtl/load_seq_pkg.sv | 37 +++
 rtl/load_extend.sv | 23 ++
 rtl/byte_load_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/load_seq_pkg.sv
// Shared load-type constants, FSM encoding and request decode helpers
// for the byte-serial load sequencer.
package load_seq_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_FLUSH,
    ST_RESP
  } state_t;

  // Index of the final byte to fetch (byte count minus one).
  function automatic logic [1:0] last_index(input logic [2:0] funct3);
    case (funct3)
      F3_LH, F3_LHU: last_index = 2'd1;
      F3_LW:         last_index = 2'd3;
      default:       last_index = 2'd0;
    endcase
  endfunction

  function automatic logic is_bad_request(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    case (funct3)
      F3_LB, F3_LBU: is_bad_request = 1'b0;
      F3_LH, F3_LHU: is_bad_request = addr_lo[0];
      F3_LW:         is_bad_request = (addr_lo != 2'b00);
      default:       is_bad_request = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of the assembled byte lanes
// according to the RV32I load type.
module load_extend
  import load_seq_pkg::*;
(
  input  logic [3:0][7:0] lanes,
  input  logic [2:0]      funct3,
  output logic [31:0]     result
);

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:  result = {{24{lanes[0][7]}}, lanes[0]};
      F3_LBU: result = {24'b0, lanes[0]};
      F3_LH:  result = {{16{lanes[1][7]}}, lanes[1], lanes[0]};
      F3_LHU: result = {16'b0, lanes[1], lanes[0]};
      F3_LW:  result = lanes;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/byte_load_sequencer.sv
// Turns one LB/LH/LW/LBU/LHU request into consecutive byte reads from a
// byte-wide synchronous memory and returns the assembled, extended word.
module byte_load_sequencer
  import load_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              stall
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_addr;
  logic [2:0]        funct3_q;
  logic [1:0]        last_idx;
  logic [1:0]        cnt;
  logic              err_q;
  logic [3:0][7:0]   lanes;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [31:0]       ext_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid)
          state_next = is_bad_request(req_funct3, req_addr[1:0]) ? ST_RESP : ST_READ;
      end
      ST_READ:  if (cnt == last_idx) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_RESP;
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Read data lags the strobe by one cycle, so the issued lane index is
  // carried along with a capture enable and written on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr <= '0;
      funct3_q  <= '0;
      last_idx  <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      lanes     <= '0;
      cap_en    <= 1'b0;
      cap_idx   <= '0;
    end else begin
      cap_en  <= mem_rd_en;
      cap_idx <= cnt;
      if (cap_en) lanes[cap_idx] <= mem_rdata;
      if (state == ST_IDLE && req_valid) begin
        base_addr <= req_addr;
        funct3_q  <= req_funct3;
        last_idx  <= last_index(req_funct3);
        cnt       <= '0;
        err_q     <= is_bad_request(req_funct3, req_addr[1:0]);
        lanes     <= '0;
      end else if (state == ST_READ && cnt != last_idx) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  load_extend u_extend (
    .lanes  (lanes),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign stall     = (state != ST_IDLE);
  assign mem_rd_en = (state == ST_READ);
  assign mem_addr  = mem_rd_en ? (base_addr + ADDR_W'(cnt)) : '0;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_data  = (rsp_valid && !err_q) ? ext_data : '0;

endmodule
